// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - FIFO pointer/flag controller for a 32x4 dual-port RAM
//
// Turns debounced write/read request levels into single-cycle push/pop
// operations and drives the RAM write enable plus the write and read
// addresses. Reports the occupancy, the full and empty flags, and
// one-cycle overflow/underflow pulses.
//
// Ports:
//   clk      in   system clock, shared with the RAM
//   reset    in   synchronous, active-high reset
//   wr_req   in   write request level (synchronized, debounced)
//   rd_req   in   read request level (synchronized, debounced)
//   wr_en    out  RAM wren, high in a cycle whose push is accepted
//   wr_addr  out  RAM wraddress (write pointer)
//   rd_addr  out  RAM rdaddress (read pointer, head of FIFO)
//   count    out  occupancy, 0..DEPTH
//   empty    out  count == 0
//   full     out  count == DEPTH
//   ovf      out  1-cycle pulse: push requested while full
//   udf      out  1-cycle pulse: pop requested while empty

module fifo_ctrl #(
    parameter  int ADDR_W = 5,
    localparam int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req,
    input  logic              rd_req,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              ovf,
    output logic              udf
);

    localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q,  count_d;
    logic              empty_q,  empty_d;
    logic              full_q,   full_d;
    logic              ovf_q,    ovf_d;
    logic              udf_q,    udf_d;
    logic              wr_req_q, wr_req_d;
    logic              rd_req_q, rd_req_d;

    logic push_req;
    logic pop_req;
    logic push_ok;
    logic pop_ok;

    always_comb begin
        push_req = wr_req & ~wr_req_q;
        pop_req  = rd_req & ~rd_req_q;

        // Reset dominates: the RAM must not see a write in a reset cycle.
        push_ok = push_req & ~full_q  & ~reset;
        pop_ok  = pop_req  & ~empty_q & ~reset;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Pointers wrap naturally modulo DEPTH.
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Flags come from next-count so they stay in step with count.
        empty_d = (count_d == '0);
        full_d  = (count_d == FULL_CNT);

        ovf_d = push_req & full_q;
        udf_d = pop_req  & empty_q;

        wr_req_d = wr_req;
        rd_req_d = rd_req;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            // Load the live levels so a request held through reset is not
            // seen as a fresh edge on release.
            wr_req_q <= wr_req;
            rd_req_q <= rd_req;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            wr_req_q <= wr_req_d;
            rd_req_q <= rd_req_d;
        end
    end

    assign wr_en   = push_ok;
    assign wr_addr = wr_ptr_q;
    assign rd_addr = rd_ptr_q;
    assign count   = count_q;
    assign empty   = empty_q;
    assign full    = full_q;
    assign ovf     = ovf_q;
    assign udf     = udf_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - scoreboard testbench for fifo_ctrl

module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_req = 1'b1;
    logic       rd_req = 1'b0;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [4:0] rd_addr;
    logic [5:0] count;
    logic       empty;
    logic       full;
    logic       ovf;
    logic       udf;

    fifo_ctrl #(.ADDR_W(5)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_req  (wr_req),
        .rd_req  (rd_req),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .rd_addr (rd_addr),
        .count   (count),
        .empty   (empty),
        .full    (full),
        .ovf     (ovf),
        .udf     (udf)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int tag;
        int rd;
    } pop_t;

    int   exp_wr[$];
    pop_t exp_pop[$];
    int   exp_ovf[$];
    int   exp_udf[$];

    int mcount = 0;
    int mwp = 0;
    int mrp = 0;
    int mtag = 0;
    int mq[$];

    task automatic model_op(input bit w, input bit r);
        bit   pa;
        bit   qa;
        pop_t e;
        pa = w && (mcount < 32);
        qa = r && (mcount > 0);
        if (qa) begin
            e.tag = mq.pop_front();
            mrp = (mrp + 1) % 32;
            e.rd = mrp;
            exp_pop.push_back(e);
        end
        if (pa) begin
            exp_wr.push_back(mwp);
            mwp = (mwp + 1) % 32;
            mq.push_back(mtag);
            mtag++;
        end
        mcount = mcount + int'(pa) - int'(qa);
        if (w && !pa) exp_ovf.push_back(mcount);
        if (r && !qa) exp_udf.push_back(mcount);
    endtask

    task automatic model_reset();
        mcount = 0;
        mwp = 0;
        mrp = 0;
        mq.delete();
    endtask

    task automatic pulse(input bit w, input bit r);
        @(posedge clk);
        #1 wr_req = w;
        rd_req = r;
        model_op(w, r);
        @(posedge clk);
        #1 wr_req = 1'b0;
        rd_req = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    // Monitor: a RAM model tagged by push order, and checks of every
    // wr_en, rd_addr advance, ovf and udf against the scoreboard queues.
    logic       mon_en = 1'b0;
    logic       rst_seen;
    logic [4:0] prev_rd;
    int         ram[32];
    int         wtag = 0;

    always @(posedge clk) rst_seen <= reset;

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_seen) begin
                prev_rd = rd_addr;
            end else if (rd_addr != prev_rd) begin
                if (exp_pop.size() > 0) begin
                    pop_t e;
                    e = exp_pop.pop_front();
                    check("pop_rd_addr", int'(rd_addr), e.rd);
                    check("pop_data_order", ram[prev_rd], e.tag);
                end else begin
                    check("pop_unexpected_rd_addr", int'(rd_addr), int'(prev_rd));
                end
                prev_rd = rd_addr;
            end
            if (wr_en) begin
                if (exp_wr.size() > 0) check("wr_addr", int'(wr_addr), exp_wr.pop_front());
                else check("wr_en_unexpected", int'(wr_en), 0);
                ram[wr_addr] = wtag;
                wtag++;
            end
            if (ovf) begin
                if (exp_ovf.size() > 0) check("ovf_count", int'(count), exp_ovf.pop_front());
                else check("ovf_unexpected", int'(ovf), 0);
            end
            if (udf) begin
                if (exp_udf.size() > 0) check("udf_count", int'(count), exp_udf.pop_front());
                else check("udf_unexpected", int'(udf), 0);
            end
        end
    end

    initial begin
        // Test 1: wr_req held high across reset release produces no push.
        repeat (3) @(posedge clk);
        #1 mon_en = 1'b1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("t1_count", int'(count), 0);
        check("t1_empty", int'(empty), 1);
        check("t1_full", int'(full), 0);
        check("t1_ovf", int'(ovf), 0);
        check("t1_udf", int'(udf), 0);
        wr_req = 1'b0;

        // Test 2: three pushes into empty.
        for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0);
        check("t2_count", int'(count), 3);
        check("t2_rd_addr", int'(rd_addr), 0);
        check("t2_wr_addr", int'(wr_addr), 3);
        check("t2_empty", int'(empty), 0);

        // Test 3: fill to 32, then one rejected push.
        for (int i = 0; i < 29; i++) pulse(1'b1, 1'b0);
        check("t3_full", int'(full), 1);
        check("t3_count", int'(count), 32);
        check("t3_wr_addr", int'(wr_addr), 0);
        pulse(1'b1, 1'b0);
        check("t3_ovf_count", int'(count), 32);
        check("t3_ovf_full", int'(full), 1);
        check("t3_ovf_wr_addr", int'(wr_addr), 0);

        // Test 4: pop from empty, then push+pop on empty.
        do_reset();
        check("t4_reset_count", int'(count), 0);
        pulse(1'b0, 1'b1);
        check("t4_udf_count", int'(count), 0);
        check("t4_udf_rd_addr", int'(rd_addr), 0);
        check("t4_udf_empty", int'(empty), 1);
        pulse(1'b1, 1'b1);
        check("t4_pp_count", int'(count), 1);
        check("t4_pp_empty", int'(empty), 0);

        // Test 5: push+pop on full, then 40 wrapping push+pop cycles.
        for (int i = 0; i < 31; i++) pulse(1'b1, 1'b0);
        check("t5_full", int'(full), 1);
        check("t5_fill_count", int'(count), 32);
        pulse(1'b1, 1'b1);
        check("t5_pp_count", int'(count), 31);
        check("t5_pp_rd_addr", int'(rd_addr), 1);
        check("t5_pp_full", int'(full), 0);
        for (int i = 0; i < 40; i++) pulse(1'b1, 1'b1);
        check("t5_wrap_count", int'(count), 31);
        check("t5_wrap_rd_addr", int'(rd_addr), 9);
        check("t5_wrap_wr_addr", int'(wr_addr), 8);

        // Test 6: held wr_req gives one push; reset mid-operation.
        do_reset();
        @(posedge clk);
        #1 wr_req = 1'b1;
        model_op(1'b1, 1'b0);
        repeat (10) @(posedge clk);
        #1 wr_req = 1'b0;
        check("t6_held_count", int'(count), 1);
        check("t6_held_wr_addr", int'(wr_addr), 1);
        for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        check("t6_pre_count", int'(count), 5);
        check("t6_pre_rd_addr", int'(rd_addr), 1);
        check("t6_pre_wr_addr", int'(wr_addr), 6);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 check("t6_rst_count", int'(count), 0);
        check("t6_rst_rd_addr", int'(rd_addr), 0);
        check("t6_rst_wr_addr", int'(wr_addr), 0);
        check("t6_rst_empty", int'(empty), 1);
        reset = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        #1 check("end_exp_wr_left", exp_wr.size(), 0);
        check("end_exp_pop_left", exp_pop.size(), 0);
        check("end_exp_ovf_left", exp_ovf.size(), 0);
        check("end_exp_udf_left", exp_udf.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
